mem_arbiter: RTL and testbench

- Sequencer sharing one single-port backing memory between the pipeline's instruction-fetch port (read-only) and its data-memory port (read/write).
- Sits between the fetch/MEM stages and the unified memory.
- Grants one requester at a time with round-robin on conflict, and holds the memory handshake until completion.
- Returns registered read data and ack, and flags hung memory transactions with a timeout.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_timeout_cnt.sv | 46 ++++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
//   state_e : arbiter sequencing states (IDLE -> BUSY -> DONE -> IDLE)
//   grant_e : which requester owns the in-flight memory transaction
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

endpackage : mem_arb_pkg

// File: rtl/arb_timeout_cnt.sv
// Watchdog counter for a memory transaction in flight.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset, clears the count
//   clr_i     : clear the count (takes priority over en_i)
//   en_i      : count one cycle without completion
//   expired_o : high in the cycle that is the TIMEOUT-th enabled cycle since
//               the last clear; never asserted when TIMEOUT is 0
module arb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // The count holds the number of earlier waiting cycles, so the limit is
  // hit while the counter still reads TIMEOUT-1.
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      // Saturate instead of wrapping so a disabled watchdog stays quiet.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule : arb_timeout_cnt

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port
// (read-only) and the data port (read/write). One transaction at a time,
// round-robin on conflict, registered read data and one-cycle acks, and a
// sticky error flag when the memory fails to answer within TIMEOUT cycles.
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   i_req_i, i_addr_i              : fetch request and address
//   i_ack_o, i_rdata_o             : fetch completion pulse and instruction
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                      : data request, write enable, address, data
//   d_ack_o, d_rdata_o             : data completion pulse and load data
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o        : memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i         : memory completion and read data
//   err_o                          : sticky timeout flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  state_e            state_q,      state_d;
  grant_e            grant_q,      grant_d;
  grant_e            last_grant_q, last_grant_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
  logic              i_ack_q,      i_ack_d;
  logic              d_ack_q,      d_ack_d;
  logic              err_q,        err_d;

  logic pick_data;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expired;

  // Data wins when it is alone, or when both ask and fetch went last.
  assign pick_data = d_req_i && (!i_req_i || (last_grant_q == GRANT_INST));

  // Watchdog only runs while a transaction is waiting on the memory.
  assign tmo_clr = (state_q != BUSY);
  assign tmo_en  = (state_q == BUSY) && !mem_ack_i;

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          if (pick_data) begin
            grant_d      = GRANT_DATA;
            last_grant_d = GRANT_DATA;
            mem_we_d     = d_we_i;
            mem_addr_d   = d_addr_i;
            mem_wdata_d  = d_wdata_i;
          end else begin
            grant_d      = GRANT_INST;
            last_grant_d = GRANT_INST;
            mem_we_d     = 1'b0;
            mem_addr_d   = i_addr_i;
            mem_wdata_d  = '0;
          end
        end
      end

      BUSY: begin
        // A real ack always beats the watchdog; expiry only fires without one.
        if (mem_ack_i || tmo_expired) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (grant_q == GRANT_DATA) begin
            d_rdata_d = mem_ack_i ? mem_rdata_i : '0;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = mem_ack_i ? mem_rdata_i : '0;
            i_ack_d   = 1'b1;
          end
          if (!mem_ack_i) begin
            err_d = 1'b1;
          end
        end
      end

      // Requests are deliberately not looked at here, so a requester still
      // holding req during its own ack pulse cannot be granted twice.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_INST;
      last_grant_q <= GRANT_INST;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
    end
  end

  assign i_ack_o     = i_ack_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A transaction-level timeline model predicts, at
// grant time, the cycles during which mem_req_o is high, the ack cycle and
// the captured data; the memory and both requesters are driven from it.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_ack_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          gap;
  } item_t;

  item_t       iq[$];
  item_t       dq[$];
  int          lat_q[$];
  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Timeline model of the transaction in flight.
  bit          m_act = 1'b0;
  int          m_own = 0;
  int          m_g = 0, m_e = 0, m_free = 0, m_ackc = -1;
  bit          m_to = 1'b0;
  int          last_own = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rval = '0, m_mval = '0;
  logic        m_we = 1'b0;
  logic [31:0] e_ir = '0, e_dr = '0;
  logic        e_err = 1'b0;
  bit          rst_req = 1'b0, rst_prev = 1'b0, stray_ack = 1'b0, allow_to = 1'b0;

  // Observations used by the literal checks.
  int          o_iack, o_dack, o_both, o_reqhi, o_last_iack;
  logic [31:0] o_irdata, o_drdata, o_addr, o_wdata;
  logic        o_we, prev_req = 1'b0;
  bit          b2b = 1'b0;
  logic [31:0] o_order[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ord(input int k);
    if (k < o_order.size()) return o_order[k];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_obs();
    o_iack = 0; o_dack = 0; o_both = 0; o_reqhi = 0; o_last_iack = 0;
    o_irdata = '0; o_drdata = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0;
    o_order.delete();
  endtask

  task automatic step();
    logic  exp_req;
    int    own, lat, ix;
    item_t t;
    @(negedge clk_i);
    cyc++;
    if (rst_prev) begin
      m_act = 1'b0; e_ir = '0; e_dr = '0; e_err = 1'b0; last_own = 0; m_free = cyc;
      check("rst_mem_addr", mem_addr_o, '0);
      check("rst_mem_wdata", mem_wdata_o, '0);
      check("rst_mem_we", {31'b0, mem_we_o}, '0);
    end
    if (m_act && cyc == m_e + 1) begin
      if (m_own == 0) e_ir = m_rval; else e_dr = m_rval;
      if (m_to) e_err = 1'b1;
    end
    exp_req = m_act && (cyc > m_g) && (cyc <= m_e);
    check("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
    if (exp_req) begin
      check("mem_addr", mem_addr_o, m_addr);
      check("mem_we", {31'b0, mem_we_o}, {31'b0, m_we});
      check("mem_wdata", mem_wdata_o, m_wdata);
    end
    check("i_ack", {31'b0, i_ack_o}, {31'b0, (m_act && cyc == m_e + 1 && m_own == 0)});
    check("d_ack", {31'b0, d_ack_o}, {31'b0, (m_act && cyc == m_e + 1 && m_own == 1)});
    check("i_rdata", i_rdata_o, e_ir);
    check("d_rdata", d_rdata_o, e_dr);
    check("err", {31'b0, err_o}, {31'b0, e_err});

    if (i_ack_o) begin o_iack++; o_irdata = i_rdata_o; o_last_iack = cyc; end
    if (d_ack_o) begin o_dack++; o_drdata = d_rdata_o; end
    if (i_ack_o && d_ack_o) o_both++;
    if (mem_req_o) begin
      o_reqhi++; o_addr = mem_addr_o; o_we = mem_we_o; o_wdata = mem_wdata_o;
      if (!prev_req) begin
        o_order.push_back(mem_addr_o);
        if (b2b && o_last_iack > 0) check("b2b_gap", cyc - o_last_iack, 2);
      end
    end
    prev_req = mem_req_o;

    mem_ack_i   = (m_act && cyc == m_ackc) || stray_ack;
    mem_rdata_i = (m_act && cyc == m_ackc) ? m_mval : $urandom();
    stray_ack   = 1'b0;

    rst_i    = rst_req;
    rst_prev = rst_req;
    if (rst_req) begin
      iq.delete(); dq.delete();
      i_req_i = 1'b0; d_req_i = 1'b0;
    end
    rst_req = 1'b0;

    if (!rst_i) begin
      if (m_act && cyc == m_e + 1) begin
        if (m_own == 0) begin
          if (iq.size() > 0) void'(iq.pop_front());
          i_req_i = 1'b0;
        end else begin
          if (dq.size() > 0) void'(dq.pop_front());
          d_req_i = 1'b0;
        end
      end
      if (!i_req_i) begin
        i_addr_i = $urandom();
        if (iq.size() > 0) begin
          t = iq[0];
          if (t.gap <= 0) begin i_req_i = 1'b1; i_addr_i = t.addr; end
          else begin t.gap--; iq[0] = t; end
        end
      end
      if (!d_req_i) begin
        d_addr_i = $urandom(); d_wdata_i = $urandom(); d_we_i = 1'($urandom());
        if (dq.size() > 0) begin
          t = dq[0];
          if (t.gap <= 0) begin
            d_req_i = 1'b1; d_addr_i = t.addr; d_we_i = t.we; d_wdata_i = t.wdata;
          end else begin t.gap--; dq[0] = t; end
        end
      end
    end

    if (!rst_i && cyc >= m_free && (i_req_i || d_req_i)) begin
      own = (d_req_i && (!i_req_i || last_own == 0)) ? 1 : 0;
      last_own = own; m_act = 1'b1; m_own = own; m_g = cyc;
      if (own == 1) begin m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i; end
      else begin m_addr = i_addr_i; m_we = 1'b0; m_wdata = '0; end
      if (lat_q.size() > 0) lat = lat_q.pop_front();
      else if (allow_to) lat = $urandom_range(0, 7);
      else lat = $urandom_range(0, 3);
      ix = int'(m_addr[9:2]);
      if (lat < TO) begin
        m_to = 1'b0; m_e = m_g + 1 + lat;
        m_mval = m_we ? $urandom() : mem[ix];
        m_rval = m_mval;
        if (m_we) mem[ix] = m_wdata;
      end else begin
        m_to = 1'b1; m_e = m_g + TO; m_mval = $urandom(); m_rval = '0;
      end
      m_ackc = (lat <= TO + 1) ? m_g + 1 + lat : -1;
      m_free = m_e + 2;
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || cyc < m_free) && n < maxc) begin
      step(); n++;
    end
    check("drain_bound", {31'b0, (n < maxc)}, 32'd1);
    step(); step();
  endtask

  task automatic push(input bit is_d, input logic [31:0] a, input logic we,
                      input logic [31:0] wd, input int gap);
    item_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.gap = gap;
    if (is_d) dq.push_back(t); else iq.push_back(t);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = $urandom();
    rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    clear_obs();
    @(negedge clk_i); @(negedge clk_i);
    rst_req = 1'b1; step(); step();

    // Fetch only.
    clear_obs();
    mem[32'h10 >> 2] = 32'h00A00093;
    lat_q.push_back(2);
    push(1'b0, 32'h10, 1'b0, 32'h0, 0);
    drain(200);
    check("fetch_ack_cnt", o_iack, 1);
    check("fetch_rdata", o_irdata, 32'h00A00093);
    check("fetch_no_dack", o_dack, 0);
    check("fetch_addr", o_addr, 32'h10);
    check("fetch_we", {31'b0, o_we}, 0);
    check("fetch_req_cycles", o_reqhi, 3);

    // Data write.
    clear_obs();
    lat_q.push_back(1);
    push(1'b1, 32'h40, 1'b1, 32'hDEADBEEF, 0);
    drain(200);
    check("wr_ack_cnt", o_dack, 1);
    check("wr_no_iack", o_iack, 0);
    check("wr_we", {31'b0, o_we}, 1);
    check("wr_wdata", o_wdata, 32'hDEADBEEF);
    check("wr_addr", o_addr, 32'h40);
    check("wr_req_cycles", o_reqhi, 2);

    // Conflict right after reset: DATA, INST, DATA.
    rst_req = 1'b1; step(); step();
    clear_obs();
    lat_q.push_back(0); lat_q.push_back(0); lat_q.push_back(0);
    push(1'b0, 32'h100, 1'b0, 32'h0, 0);
    push(1'b1, 32'h200, 1'b0, 32'h0, 0);
    push(1'b1, 32'h204, 1'b0, 32'h0, 0);
    drain(200);
    check("rr_first", ord(0), 32'h200);
    check("rr_second", ord(1), 32'h100);
    check("rr_third", ord(2), 32'h204);
    check("rr_grants", o_order.size(), 3);
    check("rr_no_dual_ack", o_both, 0);
    check("rr_iacks", o_iack, 1);
    check("rr_dacks", o_dack, 2);

    // Timeout, then err stays set through a good transaction.
    clear_obs();
    lat_q.push_back(99);
    push(1'b1, 32'h80, 1'b0, 32'h0, 0);
    drain(200);
    check("to_req_cycles", o_reqhi, 4);
    check("to_ack_cnt", o_dack, 1);
    check("to_rdata", o_drdata, 0);
    check("to_err", {31'b0, err_o}, 1);
    lat_q.push_back(0);
    push(1'b0, 32'h20, 1'b0, 32'h0, 0);
    drain(200);
    check("to_err_sticky", {31'b0, err_o}, 1);

    // Reset while BUSY, then a stray ack in IDLE.
    clear_obs();
    lat_q.push_back(99);
    push(1'b0, 32'h30, 1'b0, 32'h0, 0);
    for (int k = 0; k < 6 && !mem_req_o; k++) step();
    check("midbusy_req_seen", {31'b0, mem_req_o}, 1);
    rst_req = 1'b1; step(); step();
    check("midbusy_req_drop", {31'b0, mem_req_o}, 0);
    stray_ack = 1'b1; step(); step(); step();
    check("midbusy_no_iack", o_iack, 0);
    check("midbusy_no_dack", o_dack, 0);

    // Back-to-back fetches with req held continuously.
    clear_obs();
    b2b = 1'b1;
    for (int k = 0; k < 5; k++) push(1'b0, 32'h300 + 32'(4 * k), 1'b0, 32'h0, 0);
    drain(300);
    b2b = 1'b0;
    check("b2b_acks", o_iack, 5);

    // Randomised traffic without timeouts, then with timeouts and late acks.
    for (int ph = 0; ph < 2; ph++) begin
      rst_req = 1'b1; step(); step();
      allow_to = (ph == 1);
      for (int k = 0; k < 80; k++) begin
        push(1'b0, {22'b0, 8'($urandom()), 2'b00}, 1'b0, 32'h0,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        push(1'b1, {22'b0, 8'($urandom()), 2'b00}, 1'($urandom()), $urandom(),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      drain(5000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
